// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between the requesting units and the ring arbiter.
interface rr_ring_arbiter_if #(
  parameter int N   = 8,
  parameter int IDW = 3
);
  logic           enable;
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   ptr;

  modport master (
    output enable, req,
    input  grant, grant_valid, grant_id, ptr
  );

  modport slave (
    input  enable, req,
    output grant, grant_valid, grant_id, ptr
  );
endinterface

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a bounded hold time.
//   state | meaning
//   IDLE  | no grant outstanding; a new grant may be issued when enabled
//   BUSY  | one requester holds the resource; released on req drop or hold limit
module rr_ring_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = 3
) (
  input  logic              clock,
  input  logic              reset,
  rr_ring_arbiter_if.slave  bus
);

  localparam int HCW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [N-1:0]   grant_q, grant_n;
  logic [N-1:0]   ptr_q, ptr_n;
  logic [IDW-1:0] id_q, id_n;
  logic [HCW-1:0] hold_q, hold_n;

  logic [IDW-1:0] ptr_idx;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] scan_idx;
  logic           found;
  int             j;

  // circular scan starting at the pointer position
  always_comb begin
    ptr_idx  = '0;
    sel      = '0;
    scan_idx = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = IDW'(i);
    end
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_idx) + k;
      if (j >= N) j = j - N;
      scan_idx = IDW'(j);
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    id_n    = id_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    case (state)
      IDLE: begin
        if (bus.enable && found) begin
          grant_n = N'(1) << sel;
          id_n    = sel;
          hold_n  = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (bus.req[id_q] && (hold_q < HCW'(MAX_HOLD - 1))) begin
          hold_n = hold_q + 1'b1;
        end else begin
          grant_n = '0;
          id_n    = '0;
          ptr_n   = {grant_q[N-2:0], grant_q[N-1]};
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= N'(1);
      hold_q  <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      id_q    <= id_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_id    = id_q;
  assign bus.ptr         = ptr_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Scoreboard bench for rr_ring_arbiter: directed scenarios plus a random soak.
module tb_rr_ring_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;
  localparam int IDW      = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  rr_ring_arbiter_if #(.N(N), .IDW(IDW)) arb_if ();

  rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (arb_if.slave)
  );

  typedef struct {
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           v;
    logic [N-1:0]   p;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_busy = 1'b0;
  int m_g    = 0;
  int m_ptr  = 0;
  int m_hold = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic en, input logic [N-1:0] rq);
    if (!rst) begin
      m_busy = 1'b0; m_g = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_busy) begin
      if (en) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (rq[c] && !m_busy) begin
            m_busy = 1'b1; m_g = c; m_hold = 0;
          end
        end
      end
    end else begin
      if (rq[m_g] && m_hold < MAX_HOLD - 1) m_hold++;
      else begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % N;
      end
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [N-1:0] rq);
    exp_t e;
    int   enc;
    reset         = rst;
    arb_if.enable = en;
    arb_if.req    = rq;
    model(rst, en, rq);
    e.g  = m_busy ? (N'(1) << m_g) : '0;
    e.id = m_busy ? IDW'(m_g) : '0;
    e.v  = m_busy;
    e.p  = N'(1) << m_ptr;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check("sb_grant", 32'(arb_if.grant), 32'(e.g));
    check("sb_id",    32'(arb_if.grant_id), 32'(e.id));
    check("sb_valid", 32'(arb_if.grant_valid), 32'(e.v));
    check("sb_ptr",   32'(arb_if.ptr), 32'(e.p));
    enc = 0;
    for (int i = 0; i < N; i++) if (arb_if.grant[i]) enc = i;
    check("inv_onehot0", 32'($onehot0(arb_if.grant)), 32'd1);
    check("inv_valid",   32'(arb_if.grant_valid), 32'(|arb_if.grant));
    check("inv_id",      32'(arb_if.grant_id), 32'(enc));
    check("inv_ptr",     32'($onehot(arb_if.ptr)), 32'd1);
  endtask

  initial begin
    int            cnt;
    int            waitc [N];
    int            max_wait;
    logic [N-1:0]  cur;
    logic [N-1:0]  flip;
    logic          en;

    arb_if.enable = 1'b1;
    arb_if.req    = '0;

    // reset held with all requests pending
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    check("t1_rst_grant", 32'(arb_if.grant), 32'h00);
    check("t1_rst_valid", 32'(arb_if.grant_valid), 32'd0);
    check("t1_rst_ptr",   32'(arb_if.ptr), 32'h01);
    step(1'b1, 1'b1, 8'hFF);
    check("t1_first_grant", 32'(arb_if.grant), 32'h01);
    check("t1_first_id",    32'(arb_if.grant_id), 32'd0);

    // hold limit then wrap-around service of bit 7
    step(1'b0, 1'b1, 8'h00);
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 8'h81);
      if (arb_if.grant == 8'h01) cnt++;
    end
    check("t2_hold_len",  32'(cnt), 32'd16);
    check("t2_idle_gnt",  32'(arb_if.grant), 32'h00);
    check("t2_idle_ptr",  32'(arb_if.ptr), 32'h02);
    step(1'b1, 1'b1, 8'h81);
    check("t2_gnt7",      32'(arb_if.grant), 32'h80);
    check("t2_id7",       32'(arb_if.grant_id), 32'd7);
    step(1'b1, 1'b1, 8'h00);
    check("t2_ptr_wrap",  32'(arb_if.ptr), 32'h01);

    // short request pulse
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h10);
      check("t3_grant", 32'(arb_if.grant), 32'h10);
    end
    step(1'b1, 1'b1, 8'h00);
    check("t3_drop", 32'(arb_if.grant), 32'h00);
    check("t3_ptr",  32'(arb_if.ptr), 32'h20);

    // enable gating of new grants only
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h04);
      check("t4_gated", 32'(arb_if.grant), 32'h00);
    end
    step(1'b1, 1'b1, 8'h04);
    check("t4_grant", 32'(arb_if.grant), 32'h04);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'h04);
      check("t4_keep", 32'(arb_if.grant), 32'h04);
    end
    step(1'b1, 1'b0, 8'h00);
    check("t4_release", 32'(arb_if.grant), 32'h00);
    check("t4_ptr",     32'(arb_if.ptr), 32'h08);

    // reset during an active grant
    step(1'b1, 1'b1, 8'h08);
    check("t5_grant", 32'(arb_if.grant), 32'h08);
    step(1'b0, 1'b1, 8'h08);
    check("t5_rst_grant", 32'(arb_if.grant), 32'h00);
    check("t5_rst_ptr",   32'(arb_if.ptr), 32'h01);
    step(1'b1, 1'b0, 8'h00);
    check("t5_idle_ptr",  32'(arb_if.ptr), 32'h01);

    // random soak; starvation is measured only while enable stays high
    cur      = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      flip = '0;
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 19) == 0);
      cur = cur ^ flip;
      en  = (c >= 2000) ? 1'b1 : ($urandom_range(0, 7) != 0);
      step(1'b1, en, cur);
      if (c >= 2000) begin
        for (int i = 0; i < N; i++) begin
          if (cur[i] && !arb_if.grant[i]) waitc[i]++;
          else waitc[i] = 0;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end
      end
    end
    check("t6_starve_bound", 32'(max_wait <= N * (MAX_HOLD + 1)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
